// File: rtl/serial_byte_sender_pkg.sv
// Shared definitions for the serial byte sender.
// Contents:
//   DEFAULT_DATA_W - default bits per word / sequence counter width
//   state_e        - top-level line-ownership FSM states
//   idx_width()    - bit-index width for a given word width (never below 1)
//   DEFAULT_IDX_W  - bit-index width for DEFAULT_DATA_W
package serial_byte_sender_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [0:0] {
        WAIT_ACK,
        SEND
    } state_e;

    // A 1-bit word still needs a 1-bit index so the select logic stays legal.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DEFAULT_IDX_W = idx_width(DEFAULT_DATA_W);

endpackage

// File: rtl/serial_byte_sender_if.sv
// Half-duplex single-wire serial link.
// Signals:
//   dir  - line ownership: 1 = master drives data, 0 = partner drives data
//   data - shared bidirectional serial line (resolved wire)
// Modports:
//   master - the transmitter: owns dir, drives data only while dir=1
//   slave  - the partner: watches dir, drives data only while dir=0
interface serial_byte_sender_if;
    import serial_byte_sender_pkg::*;

    logic dir;
    wire  data;

    modport master (output dir, inout data);
    modport slave  (input dir, inout data);

endinterface

// File: rtl/serial_shift_out.sv
// Word holder and LSB-first bit serializer.
// Ports:
//   clock   - system clock, rising edge
//   reset_  - asynchronous active-high reset
//   load    - capture word and point at bit 0
//   shift   - advance to the next bit (wraps the index after the last bit)
//   word    - word to capture on load
//   bit_out - current bit (LSB of the shift register)
//   last    - current bit is the final bit of the word
module serial_shift_out
    import serial_byte_sender_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned IDX_W  = DEFAULT_IDX_W
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] word,
    output logic              bit_out,
    output logic              last
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    assign bit_out = shreg_q[0];
    assign last    = (idx_q == IDX_W'(DATA_W - 1));

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = word;
            idx_d   = '0;
        end else if (shift) begin
            shreg_d = shreg_q >> 1;
            idx_d   = last ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/serial_byte_sender.sv
// Half-duplex single-wire transmitter of an incrementing word sequence.
// Each word goes out LSB first, one bit per clock, while dir=1; the line is then
// handed back and the next word waits for the partner to hold data=1 (level ack).
// Ports:
//   clock  - system clock, rising edge
//   reset_ - asynchronous active-high reset; releases the line immediately
//   bus    - serial link (master side): dir output, data tristate
// Parameters:
//   DATA_W      - bits per word and sequence counter width
//   START_VALUE - first word after reset; sequence wraps modulo 2^DATA_W
module serial_byte_sender
    import serial_byte_sender_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned START_VALUE = 0
) (
    input  logic                 clock,
    input  logic                 reset_,
    serial_byte_sender_if.master bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              load;
    logic              shift;
    logic              drive;
    logic              tx_bit;
    logic              tx_last;

    serial_shift_out #(
        .DATA_W (DATA_W),
        .IDX_W  (idx_width(DATA_W))
    ) u_shift_out (
        .clock   (clock),
        .reset_  (reset_),
        .load    (load),
        .shift   (shift),
        .word    (word_q),
        .bit_out (tx_bit),
        .last    (tx_last)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        load    = 1'b0;
        shift   = 1'b0;
        drive   = 1'b0;
        unique case (state_q)
            WAIT_ACK: begin
                // Ack is a level: the first edge that samples 1 starts the word.
                if (bus.data == 1'b1) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                drive = 1'b1;
                shift = 1'b1;
                if (tx_last) begin
                    state_d = WAIT_ACK;
                    word_d  = word_q + DATA_W'(1);
                end
            end
            default: state_d = WAIT_ACK;
        endcase
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state_q <= WAIT_ACK;
            word_q  <= DATA_W'(START_VALUE);
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    // Driver enable is exactly dir, which is decoded straight from the state register
    // so the async reset releases the line in the same instant.
    assign bus.dir  = drive;
    assign bus.data = drive ? tx_bit : 1'bz;

endmodule

// File: tb/tb_serial_byte_sender.sv
// Scoreboard bench for serial_byte_sender: the partner process acks words with
// randomised gaps and pushes the expected word; a monitor reassembles words from
// mid-bit samples and checks them against the queue.
module tb_serial_byte_sender;
    import serial_byte_sender_pkg::*;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned START_VALUE = 0;

    logic clock = 1'b0;
    logic reset_ = 1'b1;
    logic partner_val = 1'b1;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int word_idx = 0;

    serial_byte_sender_if bus ();

    serial_byte_sender #(
        .DATA_W      (DATA_W),
        .START_VALUE (START_VALUE)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    // Partner drives the line whenever it owns it.
    assign bus.data = bus.dir ? 1'bz : partner_val;

    always #5 clock = ~clock;

    function automatic int expected_word(input int i);
        return (START_VALUE + i) % (1 << DATA_W);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Partner holds data=0 for gap edges; dir must stay low throughout.
    task automatic holdoff(input int gap);
        for (int c = 0; c < gap; c++) begin
            @(posedge clock);
            #1;
            check("holdoff_dir", bus.dir, 0);
        end
    endtask

    // Raise ack, record the expected word, and expect dir on the very next edge.
    task automatic start_word();
        partner_val = 1'b1;
        exp_q.push_back(expected_word(word_idx));
        word_idx++;
        @(posedge clock);
        #1;
        check("ack_rise_dir", bus.dir, 1);
        partner_val = 1'b0;
    endtask

    // Count dir-high periods (one already seen by start_word).
    task automatic finish_word();
        int n = 1;
        while (bus.dir && n < int'(DATA_W) + 4) begin
            @(posedge clock);
            #1;
            if (bus.dir) n++;
        end
        check("dir_width", n, DATA_W);
    endtask

    initial begin : monitor
        int cnt = 0;
        logic [DATA_W-1:0] got = '0;
        logic a_bit, a_dir, b_bit, b_dir, rst;
        forever begin
            @(posedge clock);
            #2;
            a_bit = bus.data;
            a_dir = bus.dir;
            #3;
            b_bit = bus.data;
            b_dir = bus.dir;
            rst   = reset_;
            if (!b_dir) check("no_drive", b_bit, partner_val);
            if (rst) begin
                cnt = 0;
            end else if (b_dir) begin
                if (a_dir) check("bit_stable", a_bit, b_bit);
                if (cnt < int'(DATA_W)) got[cnt] = b_bit;
                cnt++;
            end else if (cnt > 0) begin
                check("word_len", cnt, DATA_W);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got %0d, expected none", got);
                end else begin
                    check("word", got, exp_q.pop_front());
                end
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset held: line released, partner value visible on data.
        #2;
        check("rst_dir", bus.dir, 0);
        check("rst_line_hi", bus.data, 1);
        partner_val = 1'b0;
        #1;
        check("rst_line_lo", bus.data, 0);
        partner_val = 1'b1;
        @(posedge clock);
        #1;
        check("rst_hold_dir", bus.dir, 0);
        #2 reset_ = 1'b0;

        // Partner idles at 1: first word starts on the first edge.
        start_word();
        finish_word();
        for (int i = 1; i < 7; i++) begin
            holdoff(int'($urandom_range(1, 10)));
            start_word();
            finish_word();
        end

        // Word 0x07: abort with reset while bit 3 is on the line.
        holdoff(3);
        start_word();
        repeat (3) @(posedge clock);
        #3 reset_ = 1'b1;
        #1;
        check("abort_dir", bus.dir, 0);
        check("abort_line", bus.data, partner_val);
        exp_q.delete();
        word_idx = 0;
        partner_val = 1'b1;
        @(posedge clock);
        #1;
        check("abort_hold_dir", bus.dir, 0);
        #2 reset_ = 1'b0;

        // 300 words after the abort, gaps cycling 1..10, covering 0xA5 and the wrap.
        start_word();
        finish_word();
        for (int i = 1; i < 300; i++) begin
            holdoff(((i - 1) % 10) + 1);
            start_word();
            finish_word();
        end

        repeat (4) @(posedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_byte_sender.md
Name: serial_byte_sender

Overview:
- Half-duplex, single-wire serial transmitter that emits an incrementing byte sequence 0,1,…,255,0,… over a shared bidirectional line `data`.
- The `dir` output arbitrates line ownership: `dir`=1 means the block drives `data`; `dir`=0 means the partner drives it.
- Each byte is sent LSB first, one bit per clock. The block then hands the line back and waits for a level acknowledge from the partner before the next byte.
- It sits at the edge of a design, talking to an external receiver over one tristate pin.

Parameters:
- DATA_W, 8, bits per word and width of the sequence counter.
- START_VALUE, 0, first word sent after reset; the sequence wraps modulo 2^DATA_W.

Ports:
- `clock`, input, 1, system clock; all state changes on rising edge.
- `reset_`, input, 1, asynchronous, active-high reset.
- `dir`, output, 1, line ownership: 1 = block drives `data`, 0 = partner drives `data`.
- `data`, inout, 1, shared serial line; the block drives it only while `dir`=1, otherwise high-Z.

Behaviour:
- Reset (`reset_`=1, asynchronous):
  - `dir`=0 and `data` released (Z) immediately.
  - State=WAIT_ACK, word counter=START_VALUE, bit index=0.
  - Outputs remain so while reset is held.
- States: WAIT_ACK, SEND.
- WAIT_ACK:
  - `dir`=0, `data` driver off.
  - On each rising edge, sample `data`. If 1 (partner ready/ack): go to SEND, set `dir`=1, drive word[0], bit index=0.
  - If 0: remain.
- SEND:
  - `dir`=1; `data` = word[bit index]. Each bit is held exactly one clock period, changing only on rising edges.
  - Rising edge with bit index < DATA_W-1: increment bit index, drive the next bit.
  - Rising edge with bit index = DATA_W-1: go to WAIT_ACK, `dir`=0, release `data`, word counter increments (wraps 255→0), bit index=0.
- Timing:
  - `dir` is high for exactly DATA_W clock periods per word.
  - Bit j is valid from rising edge k+j to k+j+1, where k is the edge that raised `dir`. The receiver samples mid-bit.
- Ack is level-sensitive and sampled only in WAIT_ACK. `data` is never sampled in SEND.
  - After release, the partner holds `data`=0 for an arbitrary time (≥1 cycle), then raises it to 1.
  - The next `dir` rise occurs on the first rising edge that samples 1.
- Initial handshake: a partner idling `data`=1 out of reset starts the first transfer on the first rising edge after reset deasserts.
- Minimum gap: at least one cycle of `dir`=0 between words (the WAIT_ACK edge that samples the ack).
- Reset mid-transfer: `dir` drops to 0 at once and the sequence restarts at START_VALUE.
- The block must never drive `data` while `dir`=0, including on the reset edge.

Decomposition:
- Shared package `serial_byte_sender_pkg`:
  - state enum {WAIT_ACK, SEND}
  - default DATA_W
  - bit-index width constant $clog2(DATA_W)
- One natural sub-module, `serial_shift_out`:
  - holds the word, selects/shifts out the current bit LSB first, reports last-bit.
  - The top-level keeps the FSM, word counter, and tristate buffer.

Test Plan:
- Reset: hold `reset_`=1 for half a cycle → `dir`=0 and `data`=Z. Release with partner `data`=1 → `dir` rises on the first edge; bits sampled mid-bit read 0x00 LSB first; `dir` falls after exactly 8 cycles.
- Sequence: ack each word with waits cycling 1..10 cycles, 300 words → received values equal i mod 256 for i=0..299, including the wrap 255→0 at i=256.
- Ack hold-off: partner holds `data`=0 for 10 cycles after `dir` falls → `dir` stays 0 throughout. It rises one edge after `data`=1 is sampled.
- Bit timing: word 0xA5 (i=165) → mid-bit samples 1,0,1,0,0,1,0,1. `data` changes only on rising edges.
- Reset mid-transfer: assert `reset_` during bit 3 of word 0x07 → `dir`=0 and `data`=Z immediately. After release, the next word sent is 0x00.
- No-drive check: the bench drives `data` continuously while `dir`=0 → no contention (X) is ever seen on `data`.
